// File: rtl/sram_responder_if.sv
// sram_responder_if: pixel SRAM bus between the fetch/writeback initiator and the memory responder
interface sram_responder_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 24
);
  logic [ADDR_BITS-1:0] address;
  logic                 read_enable;
  logic                 write_enable;
  logic [DATA_BITS-1:0] w_data;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 w_done;
  logic                 busy;
  logic                 protocol_err;
  logic                 range_err;
  logic                 err_sticky;
  logic                 clear_err;

  modport master (
    output address, read_enable, write_enable, w_data, clear_err,
    input  r_data, r_valid, w_done, busy, protocol_err, range_err, err_sticky
  );

  modport slave (
    input  address, read_enable, write_enable, w_data, clear_err,
    output r_data, r_valid, w_done, busy, protocol_err, range_err, err_sticky
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: on-chip word array answering the pixel SRAM bus with a fixed multi-cycle access time
module sram_responder #(
  parameter int ADDR_BITS     = 16,
  parameter int DATA_BITS     = 24,
  parameter int DEPTH         = 256,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic            clk,
  input  logic            n_rst,
  sram_responder_if.slave bus
);
  localparam int                 IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]         AC  = 4'(ACCESS_CYCLES);
  localparam logic [ADDR_BITS:0] LIM = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_ACC, WR_ACC, ERR} state_t;

  state_t               r_state, w_next;
  logic [3:0]           r_count, w_count;
  logic [ADDR_BITS-1:0] r_addr, w_addr;
  logic [DATA_BITS-1:0] r_wdata, w_wdata;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_wdone, r_busy, r_perr, r_rerr, r_sticky;
  logic                 w_rd, w_wr, w_perr, w_ld, w_oor, w_same, w_both;
  logic [3:0]           w_inc;
  logic [IW-1:0]        w_idx;
  logic [DATA_BITS-1:0] r_mem [DEPTH];

  assign w_both  = bus.read_enable & bus.write_enable;
  assign w_same  = bus.address == r_addr;
  assign w_inc   = r_count + 4'd1;
  assign w_addr  = (r_state == IDLE) ? bus.address : r_addr;
  assign w_wdata = (r_state == IDLE) ? bus.w_data : r_wdata;
  assign w_idx   = w_addr[IW-1:0];
  assign w_oor   = {1'b0, w_addr} >= LIM;

  // next state, access counter and completion/abort strobes
  always_comb begin
    w_next  = r_state;
    w_count = r_count;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_perr  = 1'b0;
    w_ld    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_count = 4'd0;
        if (w_both) begin
          w_next = ERR;
          w_perr = 1'b1;
        end else if (bus.read_enable || bus.write_enable) begin
          w_ld    = 1'b1;
          w_count = 4'd1;
          w_rd    = bus.read_enable & (AC == 4'd1);
          w_wr    = bus.write_enable & (AC == 4'd1);
          w_next  = (AC == 4'd1) ? IDLE : bus.read_enable ? RD_ACC : WR_ACC;
        end
      end
      RD_ACC, WR_ACC: begin
        if (w_same && ((r_state == RD_ACC) ? (bus.read_enable && !bus.write_enable)
                                           : (bus.write_enable && !bus.read_enable))) begin
          w_count = w_inc;
          if (w_inc == AC) begin
            w_rd    = r_state == RD_ACC;
            w_wr    = r_state == WR_ACC;
            w_next  = IDLE;
            w_count = 4'd0;
          end
        end else begin
          w_perr  = 1'b1;
          w_count = 4'd0;
          w_next  = w_both ? ERR : IDLE;
        end
      end
      ERR: w_next = (!bus.read_enable && !bus.write_enable) ? IDLE : ERR;
    endcase
  end

  // state, latched request and registered response pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_count  <= 4'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_wdone  <= 1'b0;
      r_busy   <= 1'b0;
      r_perr   <= 1'b0;
      r_rerr   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_count;
      if (w_ld) begin
        r_addr  <= bus.address;
        r_wdata <= bus.w_data;
      end
      if (w_rd) r_data <= w_oor ? '0 : r_mem[w_idx];
      r_valid  <= w_rd;
      r_wdone  <= w_wr;
      r_busy   <= (w_next == RD_ACC) || (w_next == WR_ACC);
      r_perr   <= w_perr;
      r_rerr   <= (w_rd | w_wr) & w_oor;
      r_sticky <= (w_perr || ((w_rd || w_wr) && w_oor)) ? 1'b1 : bus.clear_err ? 1'b0 : r_sticky;
    end
  end

  // word array: written only on an in-range write completion outside reset
  always_ff @(posedge clk) begin
    if (w_wr && !w_oor && n_rst) r_mem[w_idx] <= w_wdata;
  end

  assign bus.r_data       = r_data;
  assign bus.r_valid      = r_valid;
  assign bus.w_done       = r_wdone;
  assign bus.busy         = r_busy;
  assign bus.protocol_err = r_perr;
  assign bus.range_err    = r_rerr;
  assign bus.err_sticky   = r_sticky;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed vector table plus reset and single-cycle-access sequences
module tb_sram_responder;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sram_responder_if #(.ADDR_BITS(16), .DATA_BITS(24)) bus ();
  sram_responder_if #(.ADDR_BITS(16), .DATA_BITS(24)) bus1 ();

  sram_responder #(.ADDR_BITS(16), .DATA_BITS(24), .DEPTH(256), .ACCESS_CYCLES(3))
    dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  sram_responder #(.ADDR_BITS(16), .DATA_BITS(24), .DEPTH(256), .ACCESS_CYCLES(1))
    dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

  // flag order: r_valid, w_done, busy, protocol_err, range_err, err_sticky
  logic [5:0] o, o1;
  assign o  = {bus.r_valid, bus.w_done, bus.busy, bus.protocol_err, bus.range_err, bus.err_sticky};
  assign o1 = {bus1.r_valid, bus1.w_done, bus1.busy, bus1.protocol_err, bus1.range_err, bus1.err_sticky};

  typedef struct {
    logic        re, we;
    logic [15:0] a;
    logic [23:0] wd;
    logic        clr;
    logic [5:0]  e;
    logic [23:0] rd;
  } vec_t;

  vec_t        vt[$];
  logic [23:0] cur;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic add(input logic re, input logic we, input logic [15:0] a, input logic [23:0] wd,
                     input logic clr, input logic [5:0] e);
    vec_t v;
    v = '{re: re, we: we, a: a, wd: wd, clr: clr, e: e, rd: cur};
    vt.push_back(v);
  endtask

  task automatic drive(input logic re, input logic we, input logic [15:0] a, input logic [23:0] wd,
                       input logic clr);
    bus.read_enable  = re;
    bus.write_enable = we;
    bus.address      = a;
    bus.w_data       = wd;
    bus.clear_err    = clr;
  endtask

  task automatic step(input string nm, input logic re, input logic we, input logic [15:0] a,
                      input logic [23:0] wd, input logic clr, input logic [5:0] e, input logic [23:0] rd);
    drive(re, we, a, wd, clr);
    @(posedge clk);
    #1;
    chk({nm, " flags"}, {18'd0, o}, {18'd0, e});
    chk({nm, " r_data"}, bus.r_data, rd);
  endtask

  initial begin
    logic [23:0] d;
    drive(0, 0, 0, 0, 0);
    bus1.read_enable = 0; bus1.write_enable = 0; bus1.address = 0; bus1.w_data = 0; bus1.clear_err = 0;
    @(posedge clk);
    #1;
    chk("reset flags", {18'd0, o}, 24'd0);
    chk("reset r_data", bus.r_data, 24'd0);
    chk("reset flags ac1", {18'd0, o1}, 24'd0);
    n_rst = 1'b1;

    cur = 24'd0;
    add(0, 1, 5, 24'hA0B0C0, 0, 6'b001000);
    add(0, 1, 5, 24'h123456, 0, 6'b001000);
    add(0, 1, 5, 24'h123456, 0, 6'b010000);
    add(1, 0, 5, 0, 0, 6'b001000);
    add(1, 0, 5, 0, 0, 6'b001000);
    cur = 24'hA0B0C0;
    add(1, 0, 5, 0, 0, 6'b100000);
    add(0, 0, 0, 0, 0, 6'b000000);
    for (int i = 0; i < 4; i++) begin
      d = 24'h111111 * 24'(i + 1);
      add(0, 1, 16'(i), d, 0, 6'b001000);
      add(0, 1, 16'(i), d, 0, 6'b001000);
      add(0, 1, 16'(i), d, 0, 6'b010000);
    end
    for (int i = 0; i < 4; i++) begin
      add(1, 0, 16'(i), 0, 0, 6'b001000);
      add(1, 0, 16'(i), 0, 0, 6'b001000);
      cur = 24'h111111 * 24'(i + 1);
      add(1, 0, 16'(i), 0, 0, 6'b100000);
    end
    add(0, 0, 0, 0, 0, 6'b000000);
    add(1, 0, 9, 0, 0, 6'b001000);
    add(1, 0, 9, 0, 0, 6'b001000);
    add(0, 0, 9, 0, 0, 6'b000101);
    add(0, 0, 0, 0, 0, 6'b000001);
    add(0, 0, 0, 0, 1, 6'b000000);
    add(1, 1, 5, 24'hFFFFFF, 0, 6'b000101);
    add(1, 1, 5, 24'hFFFFFF, 0, 6'b000001);
    add(1, 0, 5, 0, 0, 6'b000001);
    add(0, 0, 0, 0, 0, 6'b000001);
    add(0, 0, 0, 0, 1, 6'b000000);
    add(1, 0, 5, 0, 0, 6'b001000);
    add(1, 0, 5, 0, 0, 6'b001000);
    cur = 24'hA0B0C0;
    add(1, 0, 5, 0, 0, 6'b100000);
    add(0, 1, 300, 24'h5A5A5A, 0, 6'b001000);
    add(0, 1, 300, 24'h5A5A5A, 0, 6'b001000);
    add(0, 1, 300, 24'h5A5A5A, 0, 6'b010011);
    add(1, 0, 300, 0, 1, 6'b001000);
    add(1, 0, 300, 0, 0, 6'b001000);
    cur = 24'd0;
    add(1, 0, 300, 0, 1, 6'b100011);
    add(0, 0, 0, 0, 1, 6'b000000);
    add(1, 0, 5, 0, 0, 6'b001000);
    add(1, 0, 6, 0, 0, 6'b000101);
    add(0, 0, 0, 0, 1, 6'b000000);
    add(0, 1, 8, 24'h0F0F0F, 0, 6'b001000);
    add(1, 1, 8, 24'h0F0F0F, 0, 6'b000101);
    add(0, 0, 0, 0, 0, 6'b000001);
    add(0, 0, 0, 0, 1, 6'b000000);

    foreach (vt[i])
      step($sformatf("vec%0d", i), vt[i].re, vt[i].we, vt[i].a, vt[i].wd, vt[i].clr, vt[i].e, vt[i].rd);

    step("w7a", 0, 1, 7, 24'h777777, 0, 6'b001000, 24'd0);
    step("w7b", 0, 1, 7, 24'h777777, 0, 6'b001000, 24'd0);
    step("w7c", 0, 1, 7, 24'h777777, 0, 6'b010000, 24'd0);
    step("r7a", 1, 0, 7, 0, 0, 6'b001000, 24'd0);
    step("r7b", 1, 0, 7, 0, 0, 6'b001000, 24'd0);
    step("r7c", 1, 0, 7, 0, 0, 6'b100000, 24'h777777);
    step("w7 restart", 0, 1, 7, 24'hDEAD00, 0, 6'b001000, 24'h777777);
    #3;
    n_rst = 1'b0;
    #1;
    chk("async reset flags", {18'd0, o}, 24'd0);
    chk("async reset r_data", bus.r_data, 24'd0);
    @(posedge clk);
    #1;
    chk("held reset flags", {18'd0, o}, 24'd0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    step("r7 after reset a", 1, 0, 7, 0, 0, 6'b001000, 24'd0);
    step("r7 after reset b", 1, 0, 7, 0, 0, 6'b001000, 24'd0);
    step("r7 after reset c", 1, 0, 7, 0, 0, 6'b100000, 24'h777777);
    drive(0, 0, 0, 0, 0);

    bus1.write_enable = 1; bus1.address = 2; bus1.w_data = 24'hABCDEF;
    @(posedge clk);
    #1;
    chk("ac1 write flags", {18'd0, o1}, {18'd0, 6'b010000});
    bus1.write_enable = 0; bus1.read_enable = 1;
    @(posedge clk);
    #1;
    chk("ac1 read flags", {18'd0, o1}, {18'd0, 6'b100000});
    chk("ac1 read data", bus1.r_data, 24'hABCDEF);
    bus1.read_enable = 0;
    @(posedge clk);
    #1;
    chk("ac1 idle flags", {18'd0, o1}, 24'd0);
    chk("ac1 hold data", bus1.r_data, 24'hABCDEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
